// File: rtl/phase_accum_pkg.sv
// -----------------------------------------------------------------------------
// phase_accum_pkg
//   Shared phase-scaling constants and sample types for the CFO-correction
//   phase path. Phases are two's complement values scaled by
//   2**ATAN_LUT_SCALE_SHIFT, so PI is round(pi * 2**9) = 1608.
//   All phase-tracking stages take PI / PI_2 / TWO_PI from here so that
//   every stage agrees on the wrap points.
// -----------------------------------------------------------------------------
package phase_accum_pkg;

  localparam int ATAN_LUT_SCALE_SHIFT = 9;
  localparam int PI                   = 1608;
  localparam int PI_2                 = 804;
  localparam int TWO_PI               = 2 * PI;

  localparam int SAMPLE_W = 16;

  // One complex baseband sample.
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] i;
    logic signed [SAMPLE_W-1:0] q;
  } iq_sample_t;

endpackage

// File: rtl/phase_wrap.sv
// -----------------------------------------------------------------------------
// phase_wrap
//   Combinational phase adder: o_sum = wrap(i_base + i_inc) into [-PI, PI].
//   The sum is formed one bit wider than the operands so it cannot overflow,
//   then a single +/- 2PI correction is applied. One correction is enough
//   as long as both operands are already inside [-PI, PI].
//   Exactly +PI and -PI are left untouched.
//
// Ports
//   i_base  in  PHASE_WIDTH signed : current phase, in [-PI, PI]
//   i_inc   in  PHASE_WIDTH signed : phase increment, in [-PI, PI]
//   o_sum   out PHASE_WIDTH signed : wrapped sum, in [-PI, PI]
// -----------------------------------------------------------------------------
module phase_wrap
  import phase_accum_pkg::*;
#(
  parameter int PHASE_WIDTH = 32
) (
  input  logic signed [PHASE_WIDTH-1:0] i_base,
  input  logic signed [PHASE_WIDTH-1:0] i_inc,
  output logic signed [PHASE_WIDTH-1:0] o_sum
);

  localparam logic signed [PHASE_WIDTH:0] LP_PI     = (PHASE_WIDTH+1)'(PI);
  localparam logic signed [PHASE_WIDTH:0] LP_NEG_PI = -(PHASE_WIDTH+1)'(PI);
  localparam logic signed [PHASE_WIDTH:0] LP_TWO_PI = (PHASE_WIDTH+1)'(TWO_PI);

  logic signed [PHASE_WIDTH:0] w_sum;
  logic signed [PHASE_WIDTH:0] w_wrapped;

  always_comb begin
    w_sum = {i_base[PHASE_WIDTH-1], i_base} + {i_inc[PHASE_WIDTH-1], i_inc};
    if (w_sum > LP_PI) begin
      w_wrapped = w_sum - LP_TWO_PI;
    end else if (w_sum < LP_NEG_PI) begin
      w_wrapped = w_sum + LP_TWO_PI;
    end else begin
      w_wrapped = w_sum;
    end
  end

  // The corrected value always fits back into PHASE_WIDTH bits.
  assign o_sum = w_wrapped[PHASE_WIDTH-1:0];

endmodule

// File: rtl/phase_accum.sv
// -----------------------------------------------------------------------------
// phase_accum
//   Per-sample phase generator for carrier-frequency-offset correction.
//   Each strobed input sample is forwarded one cycle later together with the
//   phase the rotate stage must apply to it. The phase of sample k after a
//   clear is the wrapped sum of the increments of samples 0..k-1, so the
//   first sample after a clear always carries phase 0.
//
// Build option
//   PHASE_ACCUM_SATURATE_EN : when defined, freq_offset is clamped to
//                             [-PI, PI] as it is loaded. When undefined the
//                             value is stored as given and the upstream
//                             stage must keep |freq_offset| <= PI.
//
// Ports
//   clock            in  1    : rising-edge clock
//   reset            in  1    : asynchronous, active-high, clears all state
//   enable           in  1    : low -> all state holds, no output strobe
//   in_i, in_q       in  16   : input sample
//   input_strobe     in  1    : input sample valid
//   freq_offset      in  PW   : per-sample phase increment (signed)
//   freq_offset_load in  1    : take freq_offset as the active increment
//   clear            in  1    : restart the running phase at 0
//   out_i, out_q     out 16   : sample, one cycle after its strobe
//   phase            out PW   : correction phase for out_i/out_q
//   output_strobe    out 1    : out_i/out_q/phase valid
// -----------------------------------------------------------------------------
module phase_accum
  import phase_accum_pkg::*;
#(
  parameter int PHASE_WIDTH = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          enable,
  input  logic signed [SAMPLE_W-1:0]    in_i,
  input  logic signed [SAMPLE_W-1:0]    in_q,
  input  logic                          input_strobe,
  input  logic signed [PHASE_WIDTH-1:0] freq_offset,
  input  logic                          freq_offset_load,
  input  logic                          clear,
  output logic signed [SAMPLE_W-1:0]    out_i,
  output logic signed [SAMPLE_W-1:0]    out_q,
  output logic signed [PHASE_WIDTH-1:0] phase,
  output logic                          output_strobe
);

`ifdef PHASE_ACCUM_SATURATE_EN
  localparam logic signed [PHASE_WIDTH-1:0] LP_PI     = PHASE_WIDTH'(PI);
  localparam logic signed [PHASE_WIDTH-1:0] LP_NEG_PI = -PHASE_WIDTH'(PI);

  // Clamp a requested increment into [-PI, PI] so one wrap step stays enough.
  function automatic logic signed [PHASE_WIDTH-1:0] sat_phase(
    input logic signed [PHASE_WIDTH-1:0] v
  );
    if (v > LP_PI) begin
      return LP_PI;
    end else if (v < LP_NEG_PI) begin
      return LP_NEG_PI;
    end else begin
      return v;
    end
  endfunction
`endif

  logic signed [PHASE_WIDTH-1:0] r_inc;
  logic signed [PHASE_WIDTH-1:0] r_acc;
  logic signed [PHASE_WIDTH-1:0] r_phase_p1;
  iq_sample_t                    r_iq_p1;
  logic                          r_vld_p1;

  logic signed [PHASE_WIDTH-1:0] w_load_val;
  logic signed [PHASE_WIDTH-1:0] w_inc_eff;
  logic signed [PHASE_WIDTH-1:0] w_base;
  logic signed [PHASE_WIDTH-1:0] w_acc_next;

`ifdef PHASE_ACCUM_SATURATE_EN
  assign w_load_val = sat_phase(freq_offset);
`else
  assign w_load_val = freq_offset;
`endif

  // A load in the same cycle as a strobe already applies to that sample's
  // accumulation; a clear in the same cycle makes that sample start at 0.
  assign w_inc_eff = freq_offset_load ? w_load_val : r_inc;
  assign w_base    = clear ? '0 : r_acc;

  phase_wrap #(
    .PHASE_WIDTH (PHASE_WIDTH)
  ) u_phase_wrap (
    .i_base (w_base),
    .i_inc  (w_inc_eff),
    .o_sum  (w_acc_next)
  );

  // ---- p0 -> p1: accumulate and register the sample with its phase ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_inc      <= '0;
      r_acc      <= '0;
      r_phase_p1 <= '0;
      r_iq_p1    <= '0;
      r_vld_p1   <= 1'b0;
    end else if (enable) begin
      if (freq_offset_load) begin
        r_inc <= w_load_val;
      end
      if (input_strobe) begin
        r_phase_p1 <= w_base;
        r_iq_p1.i  <= in_i;
        r_iq_p1.q  <= in_q;
        r_vld_p1   <= 1'b1;
        r_acc      <= w_acc_next;
      end else begin
        r_vld_p1 <= 1'b0;
        if (clear) begin
          r_acc <= '0;
        end
      end
    end else begin
      // Disabled: data and phase state hold, but no new output is announced.
      r_vld_p1 <= 1'b0;
    end
  end

  assign out_i         = r_iq_p1.i;
  assign out_q         = r_iq_p1.q;
  assign phase         = r_phase_p1;
  assign output_strobe = r_vld_p1;

endmodule

// File: tb/tb_phase_accum.sv
module tb_phase_accum;

  localparam int PI     = 1608;
  localparam int TWO_PI = 3216;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic signed [15:0] in_i = '0;
  logic signed [15:0] in_q = '0;
  logic               input_strobe = 1'b0;
  logic signed [31:0] freq_offset = '0;
  logic               freq_offset_load = 1'b0;
  logic               clear = 1'b0;
  logic signed [15:0] out_i;
  logic signed [15:0] out_q;
  logic signed [31:0] phase;
  logic               output_strobe;

  int checks   = 0;
  int failures = 0;

  // Reference model state: running phase, increment, and expected outputs.
  int m_acc, m_inc, m_phase, m_i, m_q, m_vld;

  phase_accum #(.PHASE_WIDTH(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable           (enable),
    .in_i             (in_i),
    .in_q             (in_q),
    .input_strobe     (input_strobe),
    .freq_offset      (freq_offset),
    .freq_offset_load (freq_offset_load),
    .clear            (clear),
    .out_i            (out_i),
    .out_q            (out_q),
    .phase            (phase),
    .output_strobe    (output_strobe)
  );

  always #5 clock = ~clock;

  function automatic int wrapm(input longint s);
    longint v;
    v = s;
    while (v > PI)  v -= TWO_PI;
    while (v < -PI) v += TWO_PI;
    return int'(v);
  endfunction

  function automatic int loadm(input int v);
`ifdef PHASE_ACCUM_SATURATE_EN
    if (v > PI)  return PI;
    if (v < -PI) return -PI;
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    chk("rst_strobe", 64'(output_strobe), 0);
    chk("rst_phase",  64'(phase), 0);
    chk("rst_out_i",  64'(out_i), 0);
    chk("rst_out_q",  64'(out_q), 0);
    m_acc = 0; m_inc = 0; m_phase = 0; m_i = 0; m_q = 0; m_vld = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // One clock cycle of stimulus, model update and full output check.
  task automatic do_cycle(input bit stb, input bit ld, input int val,
                          input bit clr, input bit en);
    int ieff, base;
    input_strobe     = stb;
    freq_offset_load = ld;
    freq_offset      = val;
    clear            = clr;
    enable           = en;
    in_i             = 16'($urandom);
    in_q             = 16'($urandom);
    if (en) begin
      ieff = ld ? loadm(val) : m_inc;
      base = clr ? 0 : m_acc;
      if (ld) m_inc = ieff;
      if (stb) begin
        m_phase = base;
        m_i     = int'(in_i);
        m_q     = int'(in_q);
        m_vld   = 1;
        m_acc   = wrapm(longint'(base) + longint'(ieff));
      end else begin
        m_vld = 0;
        if (clr) m_acc = 0;
      end
    end else begin
      m_vld = 0;
    end
    @(posedge clock);
    #1;
    input_strobe = 1'b0; freq_offset_load = 1'b0; clear = 1'b0;
    chk("m_strobe", 64'(output_strobe), 64'(m_vld));
    chk("m_phase",  64'(phase), 64'(m_phase));
    chk("m_out_i",  64'(out_i), 64'(m_i));
    chk("m_out_q",  64'(out_q), 64'(m_q));
  endtask

  task automatic strobe_exp(input int exp_phase);
    do_cycle(1, 0, 0, 0, 1);
    chk("dir_strobe", 64'(output_strobe), 1);
    chk("dir_phase",  64'(phase), 64'(exp_phase));
  endtask

  initial begin
    int val;
    do_reset();

    // clear, load 100, five strobes
    do_cycle(0, 0, 0, 1, 1);
    do_cycle(0, 1, 100, 0, 1);
    chk("load_no_strobe", 64'(output_strobe), 0);
    strobe_exp(0); strobe_exp(100); strobe_exp(200); strobe_exp(300); strobe_exp(400);

    // positive wrap
    do_cycle(0, 1, 1000, 1, 1);
    strobe_exp(0); strobe_exp(1000); strobe_exp(-1216);

    // negative wrap
    do_cycle(0, 1, -1000, 1, 1);
    strobe_exp(0); strobe_exp(-1000); strobe_exp(1216);

    // PI kept, wraps on next add
    do_cycle(0, 1, 804, 1, 1);
    strobe_exp(0); strobe_exp(804); strobe_exp(1608); strobe_exp(-804);

    // -PI kept as well
    do_cycle(0, 1, -1608, 1, 1);
    strobe_exp(0); strobe_exp(-1608); strobe_exp(0);

    // clear together with a strobe restarts at 0
    do_cycle(0, 1, 50, 1, 1);
    strobe_exp(0); strobe_exp(50); strobe_exp(100);
    do_cycle(1, 0, 0, 1, 1);
    chk("clr_stb_phase", 64'(phase), 0);
    strobe_exp(50);

    // clear + load + strobe in one cycle
    do_cycle(1, 1, 700, 1, 1);
    chk("cls_phase", 64'(phase), 0);
    strobe_exp(700); strobe_exp(1400); strobe_exp(-1116);

`ifdef PHASE_ACCUM_SATURATE_EN
    do_cycle(0, 1, 2000, 1, 1);
    strobe_exp(0); strobe_exp(1608);
    do_cycle(0, 1, -2000, 1, 1);
    strobe_exp(0); strobe_exp(-1608);
`endif

    // enable low while strobing: no output, state holds
    do_cycle(0, 1, 10, 1, 1);
    strobe_exp(0); strobe_exp(10);
    for (int i = 0; i < 3; i++) begin
      do_cycle(1, 1, 500, 1, 0);
      chk("dis_strobe", 64'(output_strobe), 0);
    end
    strobe_exp(20); strobe_exp(30);

    // reset mid-stream: phase restarts at 0 with increment 0
    do_cycle(0, 1, 300, 0, 1);
    strobe_exp(40);
    do_reset();
    strobe_exp(0); strobe_exp(0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      val = int'($urandom_range(0, TWO_PI)) - PI;
      if ($urandom_range(0, 7) == 0) val = ($urandom_range(0, 1) == 1) ? PI : -PI;
      do_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, val,
               $urandom_range(0, 15) == 0, $urandom_range(0, 9) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
